// File: rtl/alu_comparator_if.sv
// Operand/control bus and registered result bus of the RV32IM magnitude comparator.
// The master drives operands and branch selects; the slave (comparator) returns flags.
interface alu_comparator_if #(
    parameter int data_width = 32
);
    logic                  in_valid;
    logic [data_width-1:0] operand_A;
    logic [data_width-1:0] operand_B;
    logic                  is_unsigned;
    logic [2:0]            cond_sel;

    logic                  out_valid;
    logic                  Greater;
    logic                  Equal;
    logic                  Less;
    logic                  cond_true;
    logic                  cond_illegal;

    modport master (
        output in_valid, operand_A, operand_B, is_unsigned, cond_sel,
        input  out_valid, Greater, Equal, Less, cond_true, cond_illegal
    );

    modport slave (
        input  in_valid, operand_A, operand_B, is_unsigned, cond_sel,
        output out_valid, Greater, Equal, Less, cond_true, cond_illegal
    );
endinterface

// File: rtl/alu_comparator.sv
// Registered signed/unsigned magnitude comparator with RISC-V branch condition decode.
// One result per accepted operand pair, one clock of latency, no backpressure.
module alu_comparator #(
    parameter int data_width = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_comparator_if.slave   bus
);

    // Flipping the sign bit maps two's complement order onto unsigned order,
    // so the signed compare cannot suffer subtract overflow at the extremes.
    localparam logic [data_width-1:0] SIGN_MASK = {1'b1, {(data_width-1){1'b0}}};

    logic [data_width-1:0] a_flip;
    logic [data_width-1:0] b_flip;
    logic                  eq;
    logic                  lt_u;
    logic                  gt_u;
    logic                  lt_s;
    logic                  gt_s;

    logic out_valid_q,    out_valid_d;
    logic greater_q,      greater_d;
    logic equal_q,        equal_d;
    logic less_q,         less_d;
    logic cond_true_q,    cond_true_d;
    logic cond_illegal_q, cond_illegal_d;

    always_comb begin
        a_flip = bus.operand_A ^ SIGN_MASK;
        b_flip = bus.operand_B ^ SIGN_MASK;
        eq     = (bus.operand_A == bus.operand_B);
        lt_u   = (bus.operand_A <  bus.operand_B);
        gt_u   = (bus.operand_A >  bus.operand_B);
        lt_s   = (a_flip < b_flip);
        gt_s   = (a_flip > b_flip);
    end

    always_comb begin
        out_valid_d    = 1'b0;
        greater_d      = greater_q;
        equal_d        = equal_q;
        less_d         = less_q;
        cond_true_d    = cond_true_q;
        cond_illegal_d = cond_illegal_q;

        if (bus.in_valid) begin
            out_valid_d    = 1'b1;
            equal_d        = eq;
            greater_d      = bus.is_unsigned ? gt_u : gt_s;
            less_d         = bus.is_unsigned ? lt_u : lt_s;
            cond_illegal_d = 1'b0;
            // Branch encodings fix their own signedness regardless of is_unsigned.
            unique case (bus.cond_sel)
                3'b000:  cond_true_d = eq;
                3'b001:  cond_true_d = !eq;
                3'b100:  cond_true_d = lt_s;
                3'b101:  cond_true_d = !lt_s;
                3'b110:  cond_true_d = lt_u;
                3'b111:  cond_true_d = !lt_u;
                default: begin
                    cond_true_d    = 1'b0;
                    cond_illegal_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            greater_q      <= 1'b0;
            equal_q        <= 1'b0;
            less_q         <= 1'b0;
            cond_true_q    <= 1'b0;
            cond_illegal_q <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            greater_q      <= greater_d;
            equal_q        <= equal_d;
            less_q         <= less_d;
            cond_true_q    <= cond_true_d;
            cond_illegal_q <= cond_illegal_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.Greater      = greater_q;
    assign bus.Equal        = equal_q;
    assign bus.Less         = less_q;
    assign bus.cond_true    = cond_true_q;
    assign bus.cond_illegal = cond_illegal_q;

endmodule

// File: tb/tb_alu_comparator.sv
// Scoreboard bench for alu_comparator: stimulus pushes expected flags, a monitor
// pops and compares whenever out_valid is seen.
module tb_alu_comparator;

    localparam int W = 32;

    typedef struct {
        string      name;
        logic [4:0] flags;   // {G, E, L, cond_true, cond_illegal}
    } exp_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    exp_t exp_q[$];
    logic [4:0] last_flags;

    alu_comparator_if #(.data_width(W)) bus ();

    alu_comparator #(.data_width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [5:0] act, input logic [5:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got {ov,G,E,L,ct,ci}=%b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic uns, input logic [2:0] sel);
        logic g, e, l, ct, ci;
        e  = (a == b);
        g  = uns ? (a > b) : ($signed(a) > $signed(b));
        l  = uns ? (a < b) : ($signed(a) < $signed(b));
        ci = 1'b0;
        case (sel)
            3'b000:  ct = e;
            3'b001:  ct = !e;
            3'b100:  ct = $signed(a) <  $signed(b);
            3'b101:  ct = $signed(a) >= $signed(b);
            3'b110:  ct = a <  b;
            3'b111:  ct = a >= b;
            default: begin ct = 1'b0; ci = 1'b1; end
        endcase
        return {g, e, l, ct, ci};
    endfunction

    task automatic apply_stimulus(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic uns, input logic [2:0] sel, input logic [4:0] flags);
        exp_t e;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.operand_A   = a;
        bus.operand_B   = b;
        bus.is_unsigned = uns;
        bus.cond_sel    = sel;
        e.name  = name;
        e.flags = flags;
        exp_q.push_back(e);
        last_flags = flags;
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_result: out_valid=1 with empty scoreboard");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output(e.name,
                             {bus.out_valid, bus.Greater, bus.Equal, bus.Less, bus.cond_true, bus.cond_illegal},
                             {1'b1, e.flags});
                check_output({e.name, "_onehot"},
                             {5'b0, $onehot({bus.Greater, bus.Equal, bus.Less})}, 6'b000001);
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         ru;
        logic [2:0]   rs;
        int           budget;

        tests_run       = 0;
        tests_failed    = 0;
        last_flags      = '0;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.operand_A   = '0;
        bus.operand_B   = '0;
        bus.is_unsigned = 1'b0;
        bus.cond_sel    = 3'b000;

        repeat (3) @(negedge clk);
        check_output("reset_state",
                     {bus.out_valid, bus.Greater, bus.Equal, bus.Less, bus.cond_true, bus.cond_illegal},
                     6'b000000);
        rst = 1'b0;

        // Directed G/E/L, signed, BEQ select so cond_true tracks Equal.
        apply_stimulus("s_5_vs_3",        32'd5,      32'd3,    1'b0, 3'b000, 5'b10000);
        apply_stimulus("s_m655_vs_3",     -32'sd655,  32'd3,    1'b0, 3'b000, 5'b00100);
        apply_stimulus("s_255_vs_m343",   32'd255,    -32'sd343,1'b0, 3'b000, 5'b10000);
        apply_stimulus("s_m11_vs_m346",   -32'sd11,   -32'sd346,1'b0, 3'b000, 5'b10000);
        apply_stimulus("s_8995_vs_5433",  32'd8995,   32'd5433, 1'b0, 3'b000, 5'b10000);
        apply_stimulus("s_m7_eq_m7",      -32'sd7,    -32'sd7,  1'b0, 3'b000, 5'b01010);
        // Signedness on identical operands.
        apply_stimulus("u_m655_vs_3",     32'hFFFFFD71, 32'd3,  1'b1, 3'b000, 5'b10000);
        apply_stimulus("s_m655_vs_3_bis", 32'hFFFFFD71, 32'd3,  1'b0, 3'b000, 5'b00100);
        // Extremes, with branch selects fixing their own signedness.
        apply_stimulus("s_min_vs_max_blt",  32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b100, 5'b00110);
        apply_stimulus("u_min_vs_max_bltu", 32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b110, 5'b10000);
        apply_stimulus("u_flags_blt_signed", 32'hFFFFFD71, 32'd3,       1'b1, 3'b100, 5'b10010);
        apply_stimulus("s_flags_bltu",       32'hFFFFFD71, 32'd3,       1'b0, 3'b110, 5'b00100);
        // Branch decode on A=-11, B=-346.
        apply_stimulus("br_blt",  -32'sd11, -32'sd346, 1'b0, 3'b100, 5'b10000);
        apply_stimulus("br_bge",  -32'sd11, -32'sd346, 1'b0, 3'b101, 5'b10010);
        apply_stimulus("br_bltu", -32'sd11, -32'sd346, 1'b0, 3'b110, 5'b10000);
        apply_stimulus("br_bgeu", -32'sd11, -32'sd346, 1'b0, 3'b111, 5'b10010);
        apply_stimulus("br_bne",  -32'sd11, -32'sd346, 1'b0, 3'b001, 5'b10010);
        apply_stimulus("br_beq",  -32'sd11, -32'sd346, 1'b0, 3'b000, 5'b10000);
        apply_stimulus("br_010",  -32'sd11, -32'sd346, 1'b0, 3'b010, 5'b10001);
        apply_stimulus("br_011",  32'd4,    32'd4,     1'b1, 3'b011, 5'b01001);

        // in_valid low: out_valid drops, flags hold the last result.
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.operand_A = 32'd1;
        bus.operand_B = 32'd9;
        @(negedge clk);
        check_output("hold_after_idle",
                     {bus.out_valid, bus.Greater, bus.Equal, bus.Less, bus.cond_true, bus.cond_illegal},
                     {1'b0, last_flags});

        // Reset together with in_valid discards the pending result.
        bus.in_valid  = 1'b1;
        bus.operand_A = 32'd9;
        bus.operand_B = 32'd1;
        bus.cond_sel  = 3'b010;
        rst           = 1'b1;
        @(negedge clk);
        check_output("reset_with_valid",
                     {bus.out_valid, bus.Greater, bus.Equal, bus.Less, bus.cond_true, bus.cond_illegal},
                     6'b000000);
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        // Back-to-back random pairs in both modes against a $signed/unsigned model.
        for (int i = 0; i < 2000; i++) begin
            ra = $urandom;
            rb = (i % 7 == 0) ? ra : $urandom;
            ru = i[0];
            rs = 3'($urandom_range(0, 7));
            apply_stimulus("random", ra, rb, ru, rs, model(ra, rb, ru, rs));
        end

        @(negedge clk);
        bus.in_valid = 1'b0;
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check_output("scoreboard_drained", {5'b0, exp_q.size() == 0}, 6'b000001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
